// File: rtl/lvds_rx_cnt_checker.sv
// Per-lane incrementing-counter checker for the LVDS RX test pattern: lock, mismatch counting, lock status.
// Optional sticky/first-error capture is enabled by defining LVDS_RX_CHK_STICKY_EN.
module lvds_rx_cnt_checker #(
  parameter int NUM_LANES  = 10,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic                       RX_CLK,
  input  logic                       RX_RST,
  input  logic                       LVDS_INIT_DONE,
  input  logic                       LVDS_RX_VALID,
  input  logic [8*NUM_LANES-1:0]     LVDS_RX_DATA,
  input  logic                       ERR_CLR,
  output logic [NUM_LANES-1:0]       LANE_LOCKED,
  output logic                       ALL_LOCKED,
  output logic [NUM_LANES-1:0]       ERR_PULSE,
  output logic [ERR_W*NUM_LANES-1:0] ERR_CNT,
  output logic [NUM_LANES-1:0]       DBG_LANE_STATE
`ifdef LVDS_RX_CHK_STICKY_EN
  ,
  output logic [NUM_LANES-1:0]       ERR_STICKY,
  output logic                       FIRST_ERR_VLD,
  output logic [3:0]                 FIRST_ERR_LANE
`endif
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} lane_state_e;

  localparam logic [7:0]       LOCK_CNT_B   = 8'(LOCK_CNT);
  localparam logic [7:0]       UNLOCK_CNT_B = 8'(UNLOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX      = '1;

  logic [NUM_LANES-1:0] w_lock_nxt;
  logic [NUM_LANES-1:0] w_err;
  logic                 r_all_locked;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_state_e      r_state, w_state_nxt;
    logic [7:0]       r_ref, w_ref_nxt;
    logic [7:0]       r_match, w_match_nxt;
    logic [7:0]       r_miss, w_miss_nxt;
    logic [7:0]       w_data, w_exp;
    logic             w_err_l;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_cnt;

    assign w_data = LVDS_RX_DATA[8*i +: 8];
    assign w_exp  = r_ref + 8'd1;

    always_comb begin
      w_state_nxt = r_state;
      w_ref_nxt   = r_ref;
      w_match_nxt = r_match;
      w_miss_nxt  = r_miss;
      w_err_l     = 1'b0;
      if (!LVDS_INIT_DONE) begin
        w_state_nxt = SEARCH;
        w_match_nxt = '0;
        w_miss_nxt  = '0;
      end else if (LVDS_RX_VALID) begin
        case (r_state)
          SEARCH: begin
            w_ref_nxt = w_data;
            if (w_data == w_exp) begin
              w_match_nxt = r_match + 8'd1;
              if (w_match_nxt == LOCK_CNT_B) begin
                w_state_nxt = LOCKED;
                w_match_nxt = '0;
                w_miss_nxt  = '0;
              end
            end else begin
              w_match_nxt = '0;
            end
          end
          LOCKED: begin
            // Reference free-runs so a single corrupted word costs exactly one error.
            w_ref_nxt = w_exp;
            if (w_data != w_exp) begin
              w_err_l    = 1'b1;
              w_miss_nxt = r_miss + 8'd1;
              if (w_miss_nxt == UNLOCK_CNT_B) begin
                w_state_nxt = SEARCH;
                w_match_nxt = '0;
                w_miss_nxt  = '0;
              end
            end else begin
              w_miss_nxt = '0;
            end
          end
          default: w_state_nxt = SEARCH;
        endcase
      end
    end

    always_ff @(posedge RX_CLK) begin
      if (RX_RST) begin
        r_state     <= SEARCH;
        r_ref       <= '0;
        r_match     <= '0;
        r_miss      <= '0;
        r_err_pulse <= 1'b0;
        r_err_cnt   <= '0;
      end else begin
        r_state     <= w_state_nxt;
        r_ref       <= w_ref_nxt;
        r_match     <= w_match_nxt;
        r_miss      <= w_miss_nxt;
        r_err_pulse <= w_err_l;
        // Clear wins over a same-edge increment; the pulse still fires.
        if (ERR_CLR)
          r_err_cnt <= '0;
        else if (w_err_l && (r_err_cnt != ERR_MAX))
          r_err_cnt <= r_err_cnt + 1'b1;
      end
    end

    assign w_lock_nxt[i]            = (w_state_nxt == LOCKED);
    assign w_err[i]                 = w_err_l;
    assign LANE_LOCKED[i]           = (r_state == LOCKED);
    assign DBG_LANE_STATE[i]        = r_state;
    assign ERR_PULSE[i]             = r_err_pulse;
    assign ERR_CNT[ERR_W*i +: ERR_W] = r_err_cnt;
  end

  always_ff @(posedge RX_CLK) begin
    if (RX_RST) r_all_locked <= 1'b0;
    else        r_all_locked <= &w_lock_nxt;
  end

  assign ALL_LOCKED = r_all_locked;

`ifdef LVDS_RX_CHK_STICKY_EN
  logic [NUM_LANES-1:0] r_sticky;
  logic                 r_first_vld;
  logic [3:0]           r_first_lane;
  logic [3:0]           w_low_lane;

  always_comb begin
    w_low_lane = '0;
    for (int j = NUM_LANES - 1; j >= 0; j--)
      if (w_err[j]) w_low_lane = 4'(j);
  end

  always_ff @(posedge RX_CLK) begin
    if (RX_RST) begin
      r_sticky     <= '0;
      r_first_vld  <= 1'b0;
      r_first_lane <= '0;
    end else if (ERR_CLR) begin
      r_sticky     <= w_err;
      r_first_vld  <= |w_err;
      r_first_lane <= (|w_err) ? w_low_lane : 4'd0;
    end else begin
      r_sticky <= r_sticky | w_err;
      if (!r_first_vld && (|w_err)) begin
        r_first_vld  <= 1'b1;
        r_first_lane <= w_low_lane;
      end
    end
  end

  assign ERR_STICKY     = r_sticky;
  assign FIRST_ERR_VLD  = r_first_vld;
  assign FIRST_ERR_LANE = r_first_lane;
`endif

endmodule

// File: doc/lvds_rx_cnt_checker.md
Name: lvds_rx_cnt_checker

Overview:
Receive-side checker for the LVDS link test pattern. The transmit side sends 10 independent 8-bit byte lanes, packed in an 80-bit word. Each lane carries a free-running incrementing counter (mod 256), and a single-sample +1 corruption can be injected on one selected lane. This block sits after the LVDS RX deserializer, in the RX parallel clock domain. Per lane it locks to the counter, counts mismatches and reports lock status, so link BER and the error-insertion path can be measured.

Parameters:
NUM_LANES, 10, number of 8-bit lanes in LVDS_RX_DATA
LOCK_CNT, 16, consecutive correct increments required to declare lane lock (range 2..255)
UNLOCK_CNT, 4, consecutive mismatches in lock that drop the lane back to search (range 1..255)
ERR_W, 16, width of each per-lane error counter

Ports:
RX_CLK  input  1  RX parallel clock; all logic on rising edge
RX_RST  input  1  reset, synchronous, active-high
LVDS_INIT_DONE  input  1  deserializer trained; checking is enabled only while high
LVDS_RX_VALID  input  1  LVDS_RX_DATA holds a new word this cycle
LVDS_RX_DATA  input  8*NUM_LANES  lane i = bits [8i+7:8i]
ERR_CLR  input  1  synchronous clear of all error counters
LANE_LOCKED  output  NUM_LANES  per-lane lock status
ALL_LOCKED  output  1  AND of LANE_LOCKED
ERR_PULSE  output  NUM_LANES  one-cycle pulse per counted mismatch
ERR_CNT  output  ERR_W*NUM_LANES  lane i error count = bits [ERR_W*i+ERR_W-1:ERR_W*i]

Behaviour:
- Clock and reset: single clock RX_CLK; RX_RST is synchronous and active-high.
- Reset values: LANE_LOCKED=0, ALL_LOCKED=0, ERR_PULSE=0, ERR_CNT=0. All lanes in SEARCH with match/miss counters at 0.
- Each lane runs an independent FSM with states SEARCH and LOCKED. Each lane holds an 8-bit reference register ref.
- A sample is the edge where LVDS_RX_VALID=1 and LVDS_INIT_DONE=1. On all other edges, FSM, ref and counters hold and ERR_PULSE=0.
- SEARCH:
  - ref <= data on every sample.
  - If data == ref+1 (mod 256), match_cnt increments; otherwise match_cnt <= 0.
  - When match_cnt reaches LOCK_CNT, go to LOCKED and clear miss_cnt.
  - Wrap 0xFF->0x00 counts as a match.
  - No errors are counted in SEARCH.
- LOCKED:
  - ref <= ref+1 on every sample, regardless of data. The reference free-runs, so one corrupted sample yields exactly one error, not two.
  - If data != ref+1: ERR_PULSE[i]=1 for one cycle, ERR_CNT[i] increments (saturates at 2^ERR_W-1, never wraps), miss_cnt increments.
  - If data == ref+1: miss_cnt <= 0.
  - When miss_cnt reaches UNLOCK_CNT, go to SEARCH with match_cnt=0. ERR_CNT is retained.
- Latency: all outputs are registered. The data sampled at edge k is reflected in ERR_PULSE, ERR_CNT and LANE_LOCKED after edge k (visible in cycle k+1).
- LVDS_INIT_DONE falling: on the next edge every lane returns to SEARCH, LANE_LOCKED=0 and match/miss counters are 0. ERR_CNT is retained.
- ERR_CLR:
  - Clears all ERR_CNT to 0 on that edge.
  - If a mismatch occurs on the same edge, clear wins: ERR_CNT=0, but ERR_PULSE still asserts.
  - Does not affect lock state.
- RX_RST asserted mid-operation: overrides everything and returns to reset values on that edge.
- ALL_LOCKED is registered, the same cycle as LANE_LOCKED.

Optional Feature:
LVDS_RX_CHK_STICKY_EN
- Defined: adds outputs ERR_STICKY[NUM_LANES-1:0], FIRST_ERR_VLD (1 bit) and FIRST_ERR_LANE[3:0].
  - ERR_STICKY[i] sets on any ERR_PULSE[i].
  - On the first error after reset/clear, FIRST_ERR_VLD sets and FIRST_ERR_LANE latches the lowest-index erroring lane.
  - All three clear only on RX_RST or ERR_CLR. ERR_CLR does not block a same-edge error from setting them.
- Not defined: these ports and registers do not exist. Core behaviour is identical.

Test Plan:
- Lock: all lanes count from 0x00, VALID=1, INIT_DONE=1 -> LANE_LOCKED=0x3FF and ALL_LOCKED=1 after sample 17 (16 matches); ERR_CNT all 0.
- Single insert: locked; lane 3 sends ref+2 for one sample, then resumes -> ERR_PULSE=0x008 for exactly one cycle, ERR_CNT[3]=1, other lanes 0, lane 3 stays locked.
- Unlock/relock: lane 5 sends a constant 0x55 for 4 samples -> ERR_CNT[5]=4, LANE_LOCKED[5]=0 after the 4th sample; correct counting resumes -> relock after 16 matches.
- Wrap and VALID gaps: lane counters cross 0xFF->0x00 with VALID toggling 1010 -> no errors, lock held.
- Saturation/clear: ERR_W=4, force 20 errors on lane 0 (UNLOCK_CNT=255) -> ERR_CNT[0]=15; ERR_CLR on an error edge -> ERR_CNT[0]=0 with ERR_PULSE[0]=1.
- INIT_DONE drop and reset: locked, drop INIT_DONE for 1 cycle -> LANE_LOCKED=0 next cycle and counts kept; RX_RST mid-stream -> all outputs 0 next cycle. With sticky enabled: errors on lanes 7 and 2 on the same sample -> FIRST_ERR_LANE=2, ERR_STICKY=0x084.
